proc_step_control: RTL

PROC_STEP_CONTROL -- requirements
Module: proc_step_control

---
 rtl/proc_step_control.sv | 122 ++++++++++++
 1 files changed

// File: rtl/proc_step_control.sv
// rtl/proc_step_control.sv - instruction fetch and per-step control strobe decoder
module proc_step_control (
    input  logic       MClock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] DIN,
    input  logic [1:0] Tstep,
    output logic       Clear,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       Done
);

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [8:0] ir_q, ir_d;
    logic       busy_q, busy_d;

    logic [2:0] opcode;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;
    logic       fetch;

    assign opcode   = ir_q[8:6];
    assign x_onehot = 8'd1 << ir_q[5:3];
    assign y_onehot = 8'd1 << ir_q[2:0];

    // A fetch happens only from an idle block sitting at step 0 with Run raised.
    assign fetch = ~busy_q & (Tstep == 2'd0) & Run;

    // Decode the strobes for the current step of the held instruction.
    always_comb begin
        Rin    = 8'd0;
        Rout   = 8'd0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (busy_q) begin
            case (opcode)
                OP_MV: begin
                    if (Tstep == 2'd1) begin
                        Rout = y_onehot;
                        Rin  = x_onehot;
                        Done = 1'b1;
                    end
                end
                OP_MVI: begin
                    // The immediate is whatever DIN carries during this step.
                    if (Tstep == 2'd1) begin
                        DINout = 1'b1;
                        Rin    = x_onehot;
                        Done   = 1'b1;
                    end
                end
                OP_ADD, OP_SUB: begin
                    case (Tstep)
                        2'd1: begin
                            Rout = x_onehot;
                            Ain  = 1'b1;
                        end
                        2'd2: begin
                            Rout   = y_onehot;
                            Gin    = 1'b1;
                            AddSub = (opcode == OP_SUB);
                        end
                        2'd3: begin
                            Gout = 1'b1;
                            Rin  = x_onehot;
                            Done = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    // Opcodes 1xx retire as no-ops after a single step.
                    if (Tstep == 2'd1) begin
                        Done = 1'b1;
                    end
                end
            endcase
        end
    end

    // Hold the step counter at zero whenever no instruction is progressing.
    assign Clear = Done | (~busy_q & ~((Tstep == 2'd0) & Run));

    // Next state: latch the instruction on fetch, drop busy once it retires.
    always_comb begin
        ir_d   = ir_q;
        busy_d = busy_q;
        if (fetch) begin
            ir_d   = DIN;
            busy_d = 1'b1;
        end else if (Done) begin
            busy_d = 1'b0;
        end
    end

    // State registers; reset abandons any instruction in flight.
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            ir_q   <= 9'd0;
            busy_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            busy_q <= busy_d;
        end
    end

endmodule
